// File: rtl/lifo_burst_reverser.sv
// Reverses stream frames in chunks of up to DPT words via an external stack; first output the cycle after the closing push.
// m_* outputs hold while stalled; input is refused (s_ready=0) for the whole drain of a chunk.
module lifo_burst_reverser #(
    parameter int DPT = 4,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          o_stk_push_en,
    output logic [DW-1:0] o_stk_push_data,
    input  logic          i_stk_full,
    output logic          o_stk_pop_en,
    input  logic [DW-1:0] i_stk_pop_data,
    input  logic          i_stk_empty,
    output logic          o_cut,
    output logic          o_err
);
    localparam int CW = $clog2(DPT + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DPT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_seen_q, last_seen_d;
    logic          err_q, err_d;
    logic          push_en, pop_en;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_seen_q <= last_seen_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_seen_d = last_seen_q;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        push_en     = 1'b0;
        pop_en      = 1'b0;
        o_cut       = 1'b0;
        case (state_q)
            IDLE: state_d = FILL;
            FILL: begin
                s_ready = ~i_stk_full;
                push_en = s_valid & ~i_stk_full;
                if (push_en) begin
                    cnt_d = cnt_q + CNT_ONE;
                    // s_last wins over fullness: a frame of exactly DPT words is not a cut
                    if (s_last) begin
                        state_d     = DRAIN;
                        last_seen_d = 1'b1;
                    end else if ((cnt_q + CNT_ONE) == CNT_FULL) begin
                        state_d     = DRAIN;
                        last_seen_d = 1'b0;
                        o_cut       = 1'b1;
                    end
                end
            end
            DRAIN: begin
                m_valid = ~i_stk_empty;
                pop_en  = ~i_stk_empty & m_ready;
                m_last  = ~i_stk_empty & (cnt_q == CNT_ONE) & last_seen_q;
                if (pop_en) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q
              | ((state_q == DRAIN) & (cnt_q != '0) & i_stk_empty)
              | ((state_q == FILL) & i_stk_full & (cnt_q != CNT_FULL));
    end

    assign m_data          = i_stk_pop_data;
    assign o_stk_push_en   = push_en;
    assign o_stk_push_data = s_data;
    assign o_stk_pop_en    = pop_en;
    assign o_err           = err_q;

endmodule

// File: tb/tb_lifo_burst_reverser.sv
// Bench for lifo_burst_reverser: behavioural stack, chunk-reversal reference model, scoreboard monitor.
module tb_lifo_burst_reverser;
    localparam int DPT = 4;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          o_stk_push_en;
    logic [DW-1:0] o_stk_push_data;
    logic          i_stk_full;
    logic          o_stk_pop_en;
    logic [DW-1:0] i_stk_pop_data;
    logic          i_stk_empty;
    logic          o_cut;
    logic          o_err;

    lifo_burst_reverser #(.DPT(DPT), .DW(DW)) dut (
        .clk(clk), .aresetn(aresetn),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .o_stk_push_en(o_stk_push_en), .o_stk_push_data(o_stk_push_data), .i_stk_full(i_stk_full),
        .o_stk_pop_en(o_stk_pop_en), .i_stk_pop_data(i_stk_pop_data), .i_stk_empty(i_stk_empty),
        .o_cut(o_cut), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural stack sharing the reset
    logic [DW-1:0] stk_mem [DPT];
    int            sp;
    logic          force_empty = 1'b0;
    assign i_stk_full     = (sp == DPT);
    assign i_stk_empty    = force_empty || (sp == 0);
    assign i_stk_pop_data = (sp > 0) ? stk_mem[sp-1] : '0;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sp <= 0;
        end else if (o_stk_push_en && sp < DPT) begin
            stk_mem[sp] <= o_stk_push_data;
            sp <= sp + 1;
        end else if (o_stk_pop_en && sp > 0) begin
            sp <= sp - 1;
        end
    end

    // Scoreboard monitor
    logic [DW:0]   exp_q [$];
    logic [DW-1:0] frame_q [$];
    int            cut_cnt = 0;
    int            exp_cuts = 0;
    int            pop_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !force_empty)
                check("hold_while_stalled", {22'd0, m_valid, m_last, m_data}, {22'd0, 1'b1, prev_last, prev_data});
            if (o_stk_push_en || o_stk_pop_en)
                check("push_pop_exclusive", {31'd0, o_stk_push_en & o_stk_pop_en}, 32'd0);
            if (o_cut) cut_cnt++;
            if (o_stk_pop_en) pop_cnt++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {23'd0, m_last, m_data}, 32'h1ff);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    check("out_beat", {23'd0, m_last, m_data}, {23'd0, e});
                end
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    logic rand_rdy = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int   n;
        logic acc;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        do begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 300);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    // Reference: reverse every DPT-sized chunk; only the closing chunk carries last on its first-accepted word
    task automatic issue_frame(input bit gaps);
        int len;
        len = frame_q.size();
        for (int base = 0; base < len; base += DPT) begin
            int hi;
            hi = (base + DPT < len) ? base + DPT : len;
            for (int i = hi - 1; i >= base; i--)
                exp_q.push_back({(hi == len) && (i == base), frame_q[i]});
        end
        exp_cuts += (len % DPT == 0) ? (len / DPT - 1) : (len / DPT);
        for (int i = 0; i < len; i++) begin
            send_beat(frame_q[i], i == len - 1);
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            if (gaps) #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_done", exp_q.size(), 32'd0);
    endtask

    function automatic logic [31:0] ctl_vec();
        return {25'd0, s_ready, m_valid, m_last, o_stk_push_en, o_stk_pop_en, o_cut, o_err};
    endfunction

    initial begin
        int p0;
        #3;
        check("reset_outputs", ctl_vec(), 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        check("idle_outputs", ctl_vec(), 32'd0);
        @(posedge clk);
        #1;

        // Three-beat frame, free-flowing output
        m_ready = 1'b1;
        frame_q = '{8'h11, 8'h22, 8'h33};
        issue_frame(1'b0);
        check("first_out_latency", {31'd0, m_valid}, 32'd1);
        check("no_input_in_drain", {31'd0, s_ready}, 32'd0);
        wait_drain();

        // Six-beat frame splits into a cut chunk and a closing chunk
        frame_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        issue_frame(1'b0);
        wait_drain();
        check("cut_count_6beat", cut_cnt, exp_cuts);

        // Single-beat frame
        frame_q = '{8'hA5};
        issue_frame(1'b0);
        @(posedge clk);
        #1;
        check("back_to_fill", {31'd0, s_ready}, 32'd1);
        wait_drain();

        // Stall pattern 0,1,0,1
        m_ready = 1'b0;
        p0 = pop_cnt;
        frame_q = '{8'h10, 8'h20};
        issue_frame(1'b0);
        @(posedge clk); #1; m_ready = 1'b1;
        @(posedge clk); #1; m_ready = 1'b0;
        @(posedge clk); #1; m_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_pop_count", pop_cnt - p0, 32'd2);
        wait_drain();

        // Random frames with random gaps and backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 10);
            frame_q = {};
            for (int i = 0; i < len; i++) frame_q.push_back(DW'($urandom));
            issue_frame(1'b1);
        end
        wait_drain();
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        m_ready = 1'b1;
        check("cut_count_random", cut_cnt, exp_cuts);
        check("err_clean", {31'd0, o_err}, 32'd0);

        // Reset mid-frame
        m_ready = 1'b0;
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        check("midframe_reset_outputs", ctl_vec(), 32'd0);
        @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        m_ready = 1'b1;
        frame_q = '{8'h77};
        issue_frame(1'b0);
        wait_drain();
        check("err_after_reset", {31'd0, o_err}, 32'd0);

        // Stack claims empty while two words are owed
        m_ready = 1'b0;
        frame_q = '{8'h10, 8'h20};
        issue_frame(1'b0);
        force_empty = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("err_set", {31'd0, o_err}, 32'd1);
        force_empty = 1'b0;
        m_ready = 1'b1;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", {31'd0, o_err}, 32'd1);
        aresetn = 1'b0;
        #1;
        check("err_cleared_by_reset", {31'd0, o_err}, 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
